// File: rtl/pll_hdmi_reconfig.sv
// pll_hdmi_reconfig: retunes the HDMI PLL between PAL and NTSC presets.
// Holds PLL reset, writes and verifies an MD table, then waits for lock.
module pll_hdmi_reconfig #(
   parameter int unsigned           NUM_REGS      = 4,
   parameter logic [7:0]            BASE_ADDR     = 8'h00,
   parameter logic [NUM_REGS*8-1:0] MODE0_DATA    = 32'h01_03_14_0A,
   parameter logic [NUM_REGS*8-1:0] MODE1_DATA    = 32'h01_03_19_0C,
   parameter int unsigned           RST_CYCLES    = 8,
   parameter int unsigned           SETTLE_CYCLES = 16,
   parameter int unsigned           LOCK_TIMEOUT  = 65535
) (
   input  logic       mdclk,
   input  logic       reset,
   input  logic       req,
   input  logic       mode,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       cur_mode,
   output logic       pll_rst,
   input  logic       pll_lock,
   output logic [1:0] mdopc,
   output logic       mdainc,
   output logic [7:0] mdwdi,
   input  logic [7:0] mdrdo
);

   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW_RAW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int LW = (LW_RAW < 16) ? 16 : LW_RAW;

   localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_REGS - 1);
   localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);

   localparam logic [1:0] OPC_NOP     = 2'b00;
   localparam logic [1:0] OPC_WRITE   = 2'b01;
   localparam logic [1:0] OPC_READ    = 2'b10;
   localparam logic [1:0] OPC_SETADDR = 2'b11;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_RST_HOLD  = 4'd1;
   localparam logic [3:0] ST_SETADDR_W = 4'd2;
   localparam logic [3:0] ST_WRITE     = 4'd3;
   localparam logic [3:0] ST_SETADDR_R = 4'd4;
   localparam logic [3:0] ST_READ      = 4'd5;
   localparam logic [3:0] ST_RWAIT1    = 4'd6;
   localparam logic [3:0] ST_RWAIT2    = 4'd7;
   localparam logic [3:0] ST_SETTLE    = 4'd8;
   localparam logic [3:0] ST_WAIT_LOCK = 4'd9;
   localparam logic [3:0] ST_DONE      = 4'd10;
   localparam logic [3:0] ST_FAIL      = 4'd11;

   logic [3:0]            state;
   logic                  mode_q;
   logic [IW-1:0]         idx;
   logic [RW-1:0]         rst_cnt;
   logic [SW-1:0]         settle_cnt;
   logic [LW-1:0]         lock_cnt;
   logic [NUM_REGS*8-1:0] tbl;
   logic [NUM_REGS*8-1:0] tbl_sh;
   logic [7:0]            cur_byte;

   // Table byte for the current index of the latched mode
   always_comb begin
      tbl      = mode_q ? MODE1_DATA : MODE0_DATA;
      tbl_sh   = tbl >> {idx, 3'b000};
      cur_byte = tbl_sh[7:0];
   end

   // Sequencer: reset hold, table write, read-back verify, lock wait
   always_ff @(posedge mdclk) begin
      if (reset) begin
         state      <= ST_IDLE;
         mode_q     <= 1'b0;
         idx        <= '0;
         rst_cnt    <= '0;
         settle_cnt <= '0;
         lock_cnt   <= '0;
         err        <= 1'b0;
         cur_mode   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  mode_q  <= mode;
                  err     <= 1'b0;
                  rst_cnt <= '0;
                  state   <= ST_RST_HOLD;
               end
            end
            ST_RST_HOLD: begin
               if (rst_cnt == RST_LAST) begin
                  rst_cnt <= '0;
                  state   <= ST_SETADDR_W;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            ST_SETADDR_W: begin
               idx   <= '0;
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= ST_SETADDR_R;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_SETADDR_R: begin
               idx   <= '0;
               state <= ST_READ;
            end
            ST_READ: begin
               state <= ST_RWAIT1;
            end
            ST_RWAIT1: begin
               state <= ST_RWAIT2;
            end
            ST_RWAIT2: begin
               if (mdrdo != cur_byte) begin
                  idx   <= '0;
                  err   <= 1'b1;
                  state <= ST_FAIL;
               end else if (idx == IDX_LAST) begin
                  idx        <= '0;
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_READ;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  lock_cnt   <= '0;
                  state      <= ST_WAIT_LOCK;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (pll_lock) begin
                  lock_cnt <= '0;
                  cur_mode <= mode_q;
                  state    <= ST_DONE;
               end else if (lock_cnt == LOCK_LAST) begin
                  lock_cnt <= '0;
                  err      <= 1'b1;
                  state    <= ST_FAIL;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            ST_FAIL: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state only
   always_comb begin
      busy    = (state != ST_IDLE);
      done    = (state == ST_DONE);
      pll_rst = 1'b0;
      mdopc   = OPC_NOP;
      mdainc  = 1'b0;
      mdwdi   = 8'h00;
      unique case (state)
         ST_RST_HOLD: begin
            pll_rst = 1'b1;
         end
         ST_SETADDR_W, ST_SETADDR_R: begin
            pll_rst = 1'b1;
            mdopc   = OPC_SETADDR;
            mdwdi   = BASE_ADDR;
         end
         ST_WRITE: begin
            pll_rst = 1'b1;
            mdopc   = OPC_WRITE;
            mdainc  = 1'b1;
            mdwdi   = cur_byte;
         end
         ST_READ: begin
            pll_rst = 1'b1;
            mdopc   = OPC_READ;
            mdainc  = 1'b1;
         end
         ST_RWAIT1, ST_RWAIT2: begin
            pll_rst = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/pll_hdmi_reconfig.md
# pll_hdmi_reconfig

Dynamic-reconfiguration sequencer that sits directly upstream of the HDMI PLL's MD (management data) port. On request it retunes the pixel clock between two preset configurations: mode 0 = PAL/50 Hz, mode 1 = NTSC/60 Hz.
- It holds the PLL in reset, writes a per-mode register table over the MD bus and reads it back to verify.
- It then releases reset and waits for lock with a timeout.
- It reports completion or error to the video-mode logic.

## Interface
Parameters:
- NUM_REGS, 4: bytes written per reconfiguration.
- BASE_ADDR, 8'h00: first MD register address.
- MODE0_DATA, 32'h01_03_14_0A: table for mode 0 (NUM_REGS*8 bits); byte i = bits [8i+7:8i].
- MODE1_DATA, 32'h01_03_19_0C: table for mode 1.
- RST_CYCLES, 8: PLL reset hold before the first MD access.
- SETTLE_CYCLES, 16: cycles after reset release during which pll_lock is ignored.
- LOCK_TIMEOUT, 65535: maximum cycles to wait for lock.

Ports:
- mdclk, in, 1: single clock; same clock as the PLL MD port.
- reset, in, 1: synchronous, active-high.
- req, in, 1: start request, sampled in IDLE only.
- mode, in, 1: target mode, captured when req is accepted.
- busy, out, 1: sequence in progress.
- done, out, 1: one-cycle pulse on success.
- err, out, 1: sticky error flag; cleared by the next accepted req or by reset.
- cur_mode, out, 1: last successfully applied mode.
- pll_rst, out, 1: reset to the PLL.
- pll_lock, in, 1: PLL lock; treated as synchronous to mdclk.
- mdopc, out, 2: MD opcode.
  - 00 NOP, 01 WRITE, 10 READ.
  - 11 SETADDR: mdwdi carries the address.
- mdainc, out, 1: post-increment the MD address on this WRITE/READ cycle.
- mdwdi, out, 8: MD write data / address.
- mdrdo, in, 8: MD read data, valid 2 cycles after the READ cycle.

## Operation
States: IDLE, RST_HOLD, SETADDR_W, WRITE, SETADDR_R, READ, RWAIT1, RWAIT2, SETTLE, WAIT_LOCK, DONE, FAIL.

- **IDLE:** on req=1, latch mode into mode_q, clear err, and go to RST_HOLD. If req=0, stay.
- **RST_HOLD:** pll_rst=1 for RST_CYCLES cycles, then go to SETADDR_W.
- **SETADDR_W:** 1 cycle; mdopc=11, mdwdi=BASE_ADDR; idx=0.
- **WRITE:** one cycle per byte; mdopc=01, mdainc=1, mdwdi=table[mode_q][idx].
  - idx increments each cycle.
  - After byte NUM_REGS-1, go to SETADDR_R.
- **SETADDR_R:** 1 cycle; same as SETADDR_W; idx=0.
- **READ:** 1 cycle; mdopc=10, mdainc=1. Then RWAIT1 and RWAIT2 (both NOP).
  - In RWAIT2, compare mdrdo with table[mode_q][idx].
  - Mismatch: go to FAIL.
  - Match: if idx=NUM_REGS-1 go to SETTLE; otherwise idx+1 and back to READ.
- **SETTLE:** pll_rst=0 from the first SETTLE cycle; wait SETTLE_CYCLES cycles, ignoring pll_lock.
- **WAIT_LOCK:** counter counts from 0.
  - pll_lock=1: go to DONE.
  - Counter reaches LOCK_TIMEOUT-1 with no lock: go to FAIL.
- **DONE:** 1 cycle; done=1, cur_mode<=mode_q. Then IDLE.
- **FAIL:** 1 cycle; err<=1, pll_rst=0. Then IDLE.
  - cur_mode is unchanged. The PLL config is now undefined, so software must re-request.

General rules:
- pll_rst=1 throughout RST_HOLD..RWAIT2; 0 in every other state.
- busy=1 in every state except IDLE.
- mdopc=00, mdainc=0, mdwdi=0 in every state that does not drive them.
- req while busy is ignored (no queueing). A req held high re-triggers on the first IDLE cycle.
- mode changes after acceptance have no effect on the current sequence.
- Re-requesting the current mode performs the full sequence.

## Timing
- Reset values: busy=0, done=0, err=0, cur_mode=0 (power-up PLL config is mode 0), pll_rst=0, mdopc=00, mdainc=0, mdwdi=0. State=IDLE, all counters 0.
- Reset mid-sequence: the next edge returns to IDLE with the reset values; pll_rst drops immediately.
- Outputs are registered (state-decoded from registers); no combinational path from inputs to outputs.
- busy rises the cycle after req is sampled.
- With defaults and pll_lock already high, busy is high for 8+1+4+1+12+16+1+1 = 44 cycles; done is high in the 44th.
- The SETADDR cycle directly precedes the first WRITE/READ, with no gap.
- Consecutive WRITE cycles are back-to-back.
- Each READ is followed by exactly two NOP cycles before the next READ.
- The timeout counter is ≥16 bits; counter widths are derived with $clog2 of the corresponding parameter.

## Test plan
- Reset, then req=1 mode=1 with a model PLL that locks immediately:
  - mdwdi sequence 00(SETADDR), 0C, 19, 03, 01, then SETADDR 00 and 4 READs.
  - done pulses at busy cycle 44; cur_mode=1, err=0.
- Model returns 8'h18 for the 2nd read-back: FAIL on that RWAIT2, err=1, pll_rst=0 the next cycle, cur_mode unchanged, no done.
- pll_lock held 0 with LOCK_TIMEOUT=100: err rises exactly 100 cycles after WAIT_LOCK entry; busy falls the cycle after.
- req pulsed repeatedly while busy: exactly one sequence runs, and mode toggling mid-sequence does not alter the written data.
- reset asserted during WRITE idx=2: the next cycle shows busy=0, pll_rst=0, mdopc=00; a subsequent req runs a complete sequence.
- pll_lock=1 stuck during SETTLE, then dropping to 0 at WAIT_LOCK entry and rising 10 cycles later: done occurs 10 cycles after WAIT_LOCK entry, never during SETTLE.
